// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC, drives a req/ack handshake to instruction memory that
// tolerates wait states, applies prioritized redirects (branch/jalr from EX,
// jal from ID), squashes wrong-path fetches in flight and honours StallF.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RSTN,
    input  logic        BranchE,
    input  logic [31:0] BranchTarget,
    input  logic        JalrE,
    input  logic [31:0] JalrTarget,
    input  logic        JalD,
    input  logic [31:0] JalTarget,
    input  logic        StallF,
    input  logic        IMemAck,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] PCF,
    output logic        InstValidF,
    output logic        FlushD,
    output logic        FlushE
);

    // IDLE    : out of reset, no request yet
    // REQ     : request for PCF outstanding, result is on the correct path
    // DISCARD : request for PCF outstanding but wrong-path; PT holds the target
    // HOLD    : instruction fetched but IF/ID stalled; re-request deferred
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] pt_q, pt_d;

    logic        redirect;
    logic [31:0] redir_raw;
    logic [31:0] redir_tgt;
    logic [31:0] pc_inc;

    // Redirect selection: branch beats jalr beats jal; targets word-aligned.
    always_comb begin
        redirect = BranchE | JalrE | JalD;
        if (BranchE)
            redir_raw = BranchTarget;
        else if (JalrE)
            redir_raw = JalrTarget;
        else
            redir_raw = JalTarget;
        redir_tgt = {redir_raw[31:2], 2'b00};
    end

    // Sequential PC increment wraps naturally at 2^32.
    assign pc_inc = pcf_q + 32'd4;

    // Pipeline flushes track the redirect sources directly, regardless of state.
    assign FlushD = BranchE | JalrE | JalD;
    assign FlushE = BranchE | JalrE;

    // The request address never changes while a request is in flight.
    assign IMemAddr = pcf_q;
    assign PCF      = pcf_q;

    // Next-state, next-PC, pending-target and handshake outputs.
    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        pt_d       = pt_q;
        IMemReq    = 1'b0;
        InstValidF = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                IMemReq = 1'b1;
                if (IMemAck) begin
                    if (redirect) begin
                        // Returned instruction is wrong-path; fetch target next.
                        pcf_d = redir_tgt;
                    end else if (StallF) begin
                        // IF/ID can't take it; park and re-fetch the same PC later.
                        state_d = S_HOLD;
                    end else begin
                        InstValidF = 1'b1;
                        pcf_d      = pc_inc;
                    end
                end else if (redirect) begin
                    // Cannot withdraw the request; remember where to go after it.
                    pt_d    = redir_tgt;
                    state_d = S_DISCARD;
                end
            end

            S_DISCARD: begin
                IMemReq = 1'b1;
                if (redirect)
                    pt_d = redir_tgt;
                if (IMemAck) begin
                    pcf_d   = redirect ? redir_tgt : pt_q;
                    state_d = S_REQ;
                end
            end

            S_HOLD: begin
                InstValidF = ~StallF & ~redirect;
                if (redirect) begin
                    pcf_d   = redir_tgt;
                    state_d = S_REQ;
                end else if (!StallF) begin
                    pcf_d   = pc_inc;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, PC and pending-target registers with asynchronous reset.
    always_ff @(posedge CPU_CLK or negedge CPU_RSTN) begin
        if (!CPU_RSTN) begin
            state_q <= S_IDLE;
            pcf_q   <= RESET_PC;
            pt_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            pt_q    <= pt_d;
        end
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the next-PC selection logic and the instruction-memory port. It owns the fetch PC register and drives a request/acknowledge handshake to instruction memory that tolerates wait states. It applies redirects from branch/jalr (EX) and jal (ID) with fixed priority, squashes wrong-path fetches already in flight, and honours the hazard unit's fetch stall. It also generates the ID/EX flush strobes for the pipeline registers.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset release
- CPU_CLK  in  1  clock; all state updates on rising edge
- CPU_RSTN  in  1  asynchronous, active-low reset
- BranchE  in  1  EX-stage branch taken
- BranchTarget  in  32  branch target
- JalrE  in  1  EX-stage jalr
- JalrTarget  in  32  jalr target
- JalD  in  1  ID-stage jal
- JalTarget  in  32  jal target
- StallF  in  1  hazard unit: IF/ID cannot accept an instruction this cycle
- IMemAck  in  1  one-cycle pulse; memory returns the instruction for IMemAddr this cycle
- IMemReq  out  1  fetch request outstanding
- IMemAddr  out  32  fetch address; equals PCF
- PCF  out  32  address of the in-flight or held instruction
- InstValidF  out  1  IF/ID captures a valid instruction at PCF this cycle
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register

## Operation
- Redirect priority: BranchE > JalrE > JalD. Redirect = any of the three. The selected target has bits [1:0] forced to 0.
- FlushD = BranchE|JalrE|JalD. FlushE = BranchE|JalrE. Both are combinational and not gated by state.
- Registers: state, PCF, a 32-bit pending target PT.
- States:
  - IDLE: entered on reset. IMemReq=0. Go to REQ on the first edge after reset release.
  - REQ: IMemReq=1.
    - Ack, no redirect, StallF=0: InstValidF=1; PCF<=PCF+4; stay in REQ.
    - Ack, no redirect, StallF=1: InstValidF=0; go to HOLD with PCF unchanged.
    - Ack with redirect: InstValidF=0; PCF<=target; stay in REQ.
    - Redirect without Ack: PT<=target; go to DISCARD.
  - DISCARD: IMemReq=1, IMemAddr holds the old PCF (a request is never withdrawn or changed while in flight). InstValidF=0.
    - A redirect overwrites PT; the latest redirect wins.
    - On Ack: PCF<=(redirect this cycle ? target : PT); go to REQ.
  - HOLD: IMemReq=0. InstValidF=~StallF & ~redirect.
    - Redirect: PCF<=target; go to REQ. Redirect beats StallF release.
    - Otherwise, when StallF=0: PCF<=PCF+4; go to REQ.
- StallF is ignored in DISCARD.
- PCF wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Mid-operation reset is asynchronous: state goes to IDLE, PCF to RESET_PC, and IMemReq drops immediately. Any abandoned memory response is ignored because IMemAck is a don't-care in IDLE.

## Timing
- Reset values: IMemReq=0, PCF=IMemAddr=RESET_PC, InstValidF=0, PT=0. FlushD/FlushE follow their inputs.
- Cycle 1 after reset release: IMemReq=1, IMemAddr=RESET_PC.
- Zero-wait memory (Ack in the same cycle as Req) gives one instruction per cycle.
- InstValidF, FlushD and FlushE are combinational from inputs and state. PCF, state and PT are registered.
- Redirect with Ack in the same cycle: the target is requested on the next cycle.
- Redirect in REQ without Ack: the target is requested the cycle after the old request's Ack.

## Test plan
- Reset release, IMemAck tied high, no redirects, StallF=0 → IMemAddr 0,4,8,C on consecutive cycles; InstValidF=1 each cycle.
- Ack delayed 3 cycles, then BranchE=1 with BranchTarget=32'h100 in wait cycle 1 → IMemAddr holds 0 until Ack; InstValidF=0 at Ack; next cycle IMemAddr=32'h100.
- Same cycle: BranchE(32'h200), JalrE(32'h300), JalD(32'h400), plus Ack → FlushD=FlushE=1, InstValidF=0, next IMemAddr=32'h200. With only JalD asserted → FlushD=1, FlushE=0, next IMemAddr=32'h400.
- Ack at PCF=8 with StallF=1 for 2 cycles → HOLD, IMemReq=0, InstValidF=0; StallF drops → InstValidF=1 with PCF=8; next IMemAddr=32'hC. Variant: JalD(32'h40) during HOLD → InstValidF=0, next IMemAddr=32'h40.
- In DISCARD with PT=32'h100, JalrE(32'h80) before Ack → next IMemAddr=32'h80. PCF=32'hFFFF_FFFC with Ack → next IMemAddr=0.
- CPU_RSTN asserted while in REQ at 32'h20 → IMemReq=0 and PCF=RESET_PC without a clock edge; after release, fetch restarts at RESET_PC.
